// File: rtl/mp64_mbox_arb_if.sv
// Bundle of the per-core MMIO request ports and the single slave-side port of
// the mailbox arbiter. The master modport is the arbiter's view and the slave
// modport is the view of the cores and slave around it.
interface mp64_mbox_arb_if #(
   parameter int NUM_CORES    = 4,
   parameter int CORE_ID_BITS = 2
);
   logic [NUM_CORES-1:0]    m_req;
   logic [NUM_CORES-1:0]    m_wen;
   logic [NUM_CORES*12-1:0] m_addr;
   logic [NUM_CORES*8-1:0]  m_wdata;
   logic [NUM_CORES-1:0]    m_ack;
   logic [7:0]              m_rdata;
   logic                    s_req;
   logic [11:0]             s_addr;
   logic [7:0]              s_wdata;
   logic                    s_wen;
   logic [CORE_ID_BITS-1:0] s_requester_id;
   logic [7:0]              s_rdata;
   logic                    s_ack;
   logic                    timeout_err;
   logic                    err_clr;

   modport master (
      input  m_req, m_wen, m_addr, m_wdata, s_rdata, s_ack, err_clr,
      output m_ack, m_rdata, s_req, s_addr, s_wdata, s_wen, s_requester_id, timeout_err
   );

   modport slave (
      output m_req, m_wen, m_addr, m_wdata, s_rdata, s_ack, err_clr,
      input  m_ack, m_rdata, s_req, s_addr, s_wdata, s_wen, s_requester_id, timeout_err
   );
endinterface

// File: rtl/mp64_mbox_arb.sv
// Round-robin arbiter funnelling per-core MMIO requests onto a single
// mailbox/spinlock slave, with a bounded wait for the slave acknowledge.
module mp64_mbox_arb #(
   parameter int NUM_CORES    = 4,
   parameter int CORE_ID_BITS = 2,
   parameter int TIMEOUT      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   mp64_mbox_arb_if.master      bus
);

   localparam int TW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                  state;
   logic [CORE_ID_BITS-1:0] rr_ptr;
   logic [CORE_ID_BITS-1:0] gnt_id;
   logic [TW-1:0]           tmo_cnt;

   logic                    any_req;
   logic [CORE_ID_BITS-1:0] pick;
   logic [11:0]             sel_addr;
   logic [7:0]              sel_wdata;
   logic                    sel_wen;

   // Scan upward from rr_ptr; the index width wraps modulo NUM_CORES.
   always_comb begin
      any_req   = 1'b0;
      pick      = rr_ptr;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wen   = 1'b0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         if (!any_req && bus.m_req[rr_ptr + CORE_ID_BITS'(i)]) begin
            any_req = 1'b1;
            pick    = rr_ptr + CORE_ID_BITS'(i);
         end
      end
      for (int unsigned j = 0; j < NUM_CORES; j++) begin
         if (pick == CORE_ID_BITS'(j)) begin
            sel_addr  = bus.m_addr[12*j +: 12];
            sel_wdata = bus.m_wdata[8*j +: 8];
            sel_wen   = bus.m_wen[j];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= IDLE;
         rr_ptr             <= '0;
         gnt_id             <= '0;
         tmo_cnt            <= '0;
         bus.m_ack          <= '0;
         bus.m_rdata        <= '0;
         bus.s_req          <= 1'b0;
         bus.s_addr         <= '0;
         bus.s_wdata        <= '0;
         bus.s_wen          <= 1'b0;
         bus.s_requester_id <= '0;
         bus.timeout_err    <= 1'b0;
      end else begin
         // A timeout in the same cycle overrides this clear further down.
         if (bus.err_clr)
            bus.timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               bus.m_ack <= '0;
               if (any_req) begin
                  gnt_id             <= pick;
                  tmo_cnt            <= '0;
                  bus.s_req          <= 1'b1;
                  bus.s_addr         <= sel_addr;
                  bus.s_wdata        <= sel_wdata;
                  bus.s_wen          <= sel_wen;
                  bus.s_requester_id <= pick;
                  state              <= BUSY;
               end
            end
            BUSY: begin
               if (bus.s_ack || tmo_cnt == TMO_LAST) begin
                  bus.m_rdata        <= bus.s_ack ? bus.s_rdata : 8'hFF;
                  if (!bus.s_ack)
                     bus.timeout_err <= 1'b1;
                  bus.m_ack          <= NUM_CORES'(1) << gnt_id;
                  bus.s_req          <= 1'b0;
                  bus.s_addr         <= '0;
                  bus.s_wdata        <= '0;
                  bus.s_wen          <= 1'b0;
                  bus.s_requester_id <= '0;
                  state              <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            RESP: begin
               bus.m_ack <= '0;
               rr_ptr    <= gnt_id + 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mp64_mbox_arb.sv
// Scoreboard bench for mp64_mbox_arb: directed transactions push expected
// slave requests and core responses; a negedge monitor pops and compares.
module tb_mp64_mbox_arb;

   typedef struct {
      int id;
      int addr;
      int wd;
      int wen;
      int cyc;
   } s_exp_t;

   typedef struct {
      int ack;
      int rd;
      int err;
      int cyc;
   } r_exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   probe_req = 0;
   int   probe_ack = 0;
   int   probe_kind = 0;
   int   probe_val = 0;
   logic s_prev = 1'b0;
   logic [3:0] sticky;

   s_exp_t sq[$];
   r_exp_t rq[$];

   int ta[4] = '{'h010, 'h121, 'h232, 'h343};
   int tw[4] = '{'h11, 'h22, 'h33, 'h44};
   int te[4] = '{0, 1, 0, 1};
   int tr[4] = '{'h11, 'h22, 'h33, 'h44};

   mp64_mbox_arb_if #(.NUM_CORES(4), .CORE_ID_BITS(2)) bus ();

   mp64_mbox_arb #(.NUM_CORES(4), .CORE_ID_BITS(2), .TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Slave read data model: low address byte plus one.
   assign bus.s_rdata = bus.s_addr[7:0] + 8'h01;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void mon();
      s_exp_t se;
      r_exp_t re;
      if (probe_req != probe_ack) begin
         probe_ack = probe_req;
         case (probe_kind)
            0: chk("timeout_err", int'(bus.timeout_err), probe_val);
            1: chk("reset_outputs", int'({bus.m_ack, bus.m_rdata, bus.s_req, bus.s_addr,
                                          bus.s_wdata, bus.s_wen, bus.s_requester_id,
                                          bus.timeout_err}), 0);
            default: chk("drain", sq.size() + rq.size(), 0);
         endcase
      end
      if (!rst) begin
         if (bus.s_req && !s_prev) begin
            if (sq.size() == 0) chk("s_req_unexpected", 1, 0);
            else begin
               se = sq.pop_front();
               chk("s_requester_id", int'(bus.s_requester_id), se.id);
               chk("s_addr", int'(bus.s_addr), se.addr);
               chk("s_wdata", int'(bus.s_wdata), se.wd);
               chk("s_wen", int'(bus.s_wen), se.wen);
               chk("s_req_cycle", cyc, se.cyc);
            end
         end
         if (!bus.s_req)
            chk("s_idle_zero", int'({bus.s_addr, bus.s_wdata, bus.s_wen, bus.s_requester_id}), 0);
         if (bus.m_ack != 4'b0000) begin
            if (rq.size() == 0) chk("m_ack_unexpected", int'(bus.m_ack), 0);
            else begin
               re = rq.pop_front();
               chk("m_ack", int'(bus.m_ack), re.ack);
               chk("m_rdata", int'(bus.m_rdata), re.rd);
               chk("ack_timeout_err", int'(bus.timeout_err), re.err);
               chk("m_ack_cycle", cyc, re.cyc);
            end
         end
      end else if (bus.m_ack != 4'b0000) begin
         chk("m_ack_in_reset", int'(bus.m_ack), 0);
      end
      s_prev = bus.s_req;
   endfunction

   always @(negedge clk) mon();

   // Cores drop m_req on seeing their ack unless marked sticky.
   task automatic tick();
      @(posedge clk);
      #1;
      bus.m_req = bus.m_req & ~(bus.m_ack & ~sticky);
   endtask

   task automatic probe(int kind, int val);
      probe_kind = kind;
      probe_val  = val;
      probe_req++;
      @(negedge clk);
      #1;
   endtask

   task automatic exp_s(int id, int addr, int wd, int wen, int c);
      sq.push_back(s_exp_t'{id, addr, wd, wen, c});
   endtask

   task automatic exp_r(int ack, int rd, int err, int c);
      rq.push_back(r_exp_t'{ack, rd, err, c});
   endtask

   task automatic set_core(int i, int addr, int wd, int wen);
      bus.m_addr[12*i +: 12] = addr[11:0];
      bus.m_wdata[8*i +: 8]  = wd[7:0];
      bus.m_wen[i]           = wen[0];
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 80; i++) begin
         if (sq.size() == 0 && rq.size() == 0 && bus.m_req == 4'b0000) break;
         tick();
      end
      tick();
      tick();
      probe(2, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      probe(1, 0);
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      int c;
      rst         = 1'b1;
      sticky      = 4'b0000;
      bus.m_req   = '0;
      bus.m_wen   = '0;
      bus.m_addr  = '0;
      bus.m_wdata = '0;
      bus.s_ack   = 1'b1;
      bus.err_clr = 1'b0;
      do_reset();
      tick();

      // Core 2 write, single-cycle slave
      set_core(2, 'h500, 'hAB, 1);
      c = cyc;
      exp_s(2, 'h500, 'hAB, 1, c + 1);
      exp_r('b0100, 'h01, 0, c + 2);
      bus.m_req = 4'b0100;
      wait_idle();

      // All four cores after reset: order 0,1,2,3 every 3 cycles
      do_reset();
      for (int k = 0; k < 4; k++) set_core(k, ta[k], tw[k], te[k]);
      c = cyc;
      for (int k = 0; k < 4; k++) begin
         exp_s(k, ta[k], tw[k], te[k], c + 1 + 3 * k);
         exp_r(1 << k, tr[k], 0, c + 2 + 3 * k);
      end
      bus.m_req = 4'b1111;
      wait_idle();

      // Cores 1 and 3 hold requests: alternate 1,3,1,3
      sticky = 4'b1010;
      c = cyc;
      for (int k = 0; k < 4; k++) begin
         int id;
         id = (k % 2 == 0) ? 1 : 3;
         exp_s(id, ta[id], tw[id], te[id], c + 1 + 3 * k);
         exp_r(1 << id, tr[id], 0, c + 2 + 3 * k);
      end
      bus.m_req = 4'b1010;
      repeat (11) tick();
      bus.m_req = 4'b0000;
      sticky    = 4'b0000;
      wait_idle();

      // Core 1 read of 0x600
      set_core(1, 'h600, 'h00, 0);
      c = cyc;
      exp_s(1, 'h600, 'h00, 0, c + 1);
      exp_r('b0010, 'h01, 0, c + 2);
      bus.m_req = 4'b0010;
      wait_idle();

      // Slave never acks: 16 BUSY cycles, then 0xFF and sticky error
      bus.s_ack = 1'b0;
      set_core(0, 'h010, 'h11, 0);
      c = cyc;
      exp_s(0, 'h010, 'h11, 0, c + 1);
      exp_r('b0001, 'hFF, 1, c + 17);
      bus.m_req = 4'b0001;
      wait_idle();
      probe(0, 1);
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      probe(0, 0);

      // Timeout with err_clr held: set wins in the timeout cycle
      bus.err_clr = 1'b1;
      c = cyc;
      exp_s(0, 'h010, 'h11, 0, c + 1);
      exp_r('b0001, 'hFF, 1, c + 17);
      bus.m_req = 4'b0001;
      wait_idle();
      bus.err_clr = 1'b0;
      probe(0, 0);
      bus.s_ack = 1'b1;

      // Reset mid-BUSY: core 3 granted (rr_ptr=1), discarded; core 0 wins after
      set_core(3, 'h343, 'h44, 1);
      c = cyc;
      exp_s(3, 'h343, 'h44, 1, c + 1);
      bus.m_req = 4'b1001;
      tick();
      @(negedge clk);
      #1;
      rst = 1'b1;
      probe(1, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      c = cyc;
      exp_s(0, 'h010, 'h11, 0, c + 1);
      exp_r('b0001, 'h11, 0, c + 2);
      exp_s(3, 'h343, 'h44, 1, c + 4);
      exp_r('b1000, 'h44, 0, c + 5);
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

endmodule
